// File: rtl/ext_adc_pkg.sv
// Shared types and helpers for the multi-channel external ADC scanner.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ext_adc_pkg;

    typedef enum logic [2:0] {
        ST_DISABLED = 3'd0,
        ST_IDLE     = 3'd1,
        ST_POWERUP  = 3'd2,
        ST_CONVERT  = 3'd3,
        ST_EVAL     = 3'd4,
        ST_NOTIFY   = 3'd5
    } state_t;

    // Channel-index width; a single-channel build still needs a 1-bit select.
    function automatic int CH_IDX_W(input int num_ch);
        int w;
        w = $clog2(num_ch);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/ext_adc_scan_if.sv
// Sensor power/ready and ADC request/done handshake bundle.
// Latency: n/a (wires only).
// Backpressure: level handshakes; the ADC holds AdcDone_i until AdcStart_o drops.
interface ext_adc_scan_if
    import ext_adc_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int NUM_CH = 4
);
    localparam int IW = CH_IDX_W(NUM_CH);

    logic             SensorPower_o;
    logic             SensorStart_o;
    logic             SensorReady_i;
    logic             AdcStart_o;
    logic [IW-1:0]    AdcChannel_o;
    logic             AdcDone_i;
    logic [WIDTH-1:0] AdcValue_i;

    // Scanner side
    modport master (
        output SensorPower_o, SensorStart_o, AdcStart_o, AdcChannel_o,
        input  SensorReady_i, AdcDone_i, AdcValue_i
    );

    // Sensor / ADC side
    modport slave (
        input  SensorPower_o, SensorStart_o, AdcStart_o, AdcChannel_o,
        output SensorReady_i, AdcDone_i, AdcValue_i
    );
endinterface

// File: rtl/ext_adc_timer.sv
// Loadable down-counter that saturates at zero and flags it.
// Latency: Zero_o reflects the registered count (load/decrement visible next cycle).
// Backpressure: none; Enable_i gates the decrement, Load_i has priority.
module ext_adc_timer #(
    parameter int TIMER_WIDTH = 16
) (
    input  logic                   Clk_i,
    input  logic                   Reset_i,
    input  logic                   Load_i,
    input  logic [TIMER_WIDTH-1:0] Preset_i,
    input  logic                   Enable_i,
    output logic                   Zero_o
);
    logic [TIMER_WIDTH-1:0] count_q, count_d;

    // Next count: load wins, otherwise decrement towards zero when enabled
    always_comb begin
        count_d = count_q;
        if (Load_i) begin
            count_d = Preset_i;
        end else if (Enable_i && (count_q != '0)) begin
            count_d = count_q - TIMER_WIDTH'(1);
        end
    end

    // Count register
    always_ff @(posedge Clk_i) begin
        if (Reset_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign Zero_o = (count_q == '0);

endmodule

// File: rtl/ext_adc_scan.sv
// Periodic multi-channel ADC scan with per-channel change detection and CPU interrupt.
// Latency: one period = preset+1 idle cycles, powerup, then per channel CONVERT(until done)+EVAL, then NOTIFY.
// Backpressure: waits indefinitely on AdcDone_i; SensorReady_i wait bounded by ReadyTimeout_i.
module ext_adc_scan
    import ext_adc_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int NUM_CH      = 4,
    parameter int TIMER_WIDTH = 16
) (
    input  logic                    Clk_i,
    input  logic                    Reset_i,
    input  logic                    Enable_i,
    input  logic [TIMER_WIDTH-1:0]  PeriodCounterPreset_i,
    input  logic [TIMER_WIDTH-1:0]  ReadyTimeout_i,
    input  logic [NUM_CH*WIDTH-1:0] Threshold_i,
    ext_adc_scan_if.master          adc,
    output logic [NUM_CH*WIDTH-1:0] SensorValue_o,
    output logic [NUM_CH-1:0]       ChangedMask_o,
    output logic                    CpuIntr_o,
    output logic                    Error_o,
    input  logic                    ErrorClr_i
);
    localparam int             IW       = CH_IDX_W(NUM_CH);
    localparam logic [IW-1:0]  LAST_IDX = IW'(NUM_CH - 1);

    state_t                state_q, state_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [WIDTH-1:0]      sample_q, sample_d;
    logic [NUM_CH-1:0]     round_mask_q, round_mask_d;
    logic [NUM_CH-1:0]     changed_mask_q, changed_mask_d;
    logic                  error_q, error_d;
    logic [WIDTH-1:0]      stored_q [NUM_CH];
    logic [WIDTH-1:0]      stored_d [NUM_CH];
    logic [WIDTH-1:0]      thr_arr  [NUM_CH];

    logic                  period_load, period_dec, period_zero;
    logic                  rdy_load, rdy_dec, rdy_zero;
    logic                  ready_timeout;
    logic [WIDTH-1:0]      cur_stored, diff;
    logic                  over_thr;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        assign thr_arr[k]                     = Threshold_i[k*WIDTH +: WIDTH];
        assign SensorValue_o[k*WIDTH +: WIDTH] = stored_q[k];
    end

    assign ChangedMask_o = changed_mask_q;
    assign Error_o       = error_q;

    // Ready wait expired this cycle (sensor still not ready with counter at zero)
    assign ready_timeout = (state_q == ST_POWERUP) && !adc.SensorReady_i && rdy_zero;

    // Timer controls: period reloads on every entry to IDLE, timeout loads on entry to POWERUP
    always_comb begin
        period_load = Enable_i && ((state_q == ST_DISABLED) || ready_timeout || (state_q == ST_NOTIFY));
        period_dec  = Enable_i && (state_q == ST_IDLE);
        rdy_load    = Enable_i && (state_q == ST_IDLE) && period_zero;
        rdy_dec     = Enable_i && (state_q == ST_POWERUP) && !adc.SensorReady_i;
    end

    ext_adc_timer #(.TIMER_WIDTH(TIMER_WIDTH)) u_period_timer (
        .Clk_i    (Clk_i),
        .Reset_i  (Reset_i),
        .Load_i   (period_load),
        .Preset_i (PeriodCounterPreset_i),
        .Enable_i (period_dec),
        .Zero_o   (period_zero)
    );

    ext_adc_timer #(.TIMER_WIDTH(TIMER_WIDTH)) u_ready_timer (
        .Clk_i    (Clk_i),
        .Reset_i  (Reset_i),
        .Load_i   (rdy_load),
        .Preset_i (ReadyTimeout_i),
        .Enable_i (rdy_dec),
        .Zero_o   (rdy_zero)
    );

    // Unsigned distance between the fresh sample and the stored value of the current channel
    always_comb begin
        cur_stored = stored_q[idx_q];
        diff       = (sample_q >= cur_stored) ? (sample_q - cur_stored) : (cur_stored - sample_q);
        over_thr   = (diff > thr_arr[idx_q]);
    end

    // State and datapath registers
    always_ff @(posedge Clk_i) begin
        if (Reset_i) begin
            state_q        <= ST_DISABLED;
            idx_q          <= '0;
            sample_q       <= '0;
            round_mask_q   <= '0;
            changed_mask_q <= '0;
            error_q        <= 1'b0;
            for (int k = 0; k < NUM_CH; k++) begin
                stored_q[k] <= '0;
            end
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            sample_q       <= sample_d;
            round_mask_q   <= round_mask_d;
            changed_mask_q <= changed_mask_d;
            error_q        <= error_d;
            for (int k = 0; k < NUM_CH; k++) begin
                stored_q[k] <= stored_d[k];
            end
        end
    end

    // Next-state logic; dropping Enable_i aborts from any state
    always_comb begin
        state_d = state_q;
        if (!Enable_i) begin
            state_d = ST_DISABLED;
        end else begin
            case (state_q)
                ST_DISABLED: state_d = ST_IDLE;
                ST_IDLE:     if (period_zero) state_d = ST_POWERUP;
                ST_POWERUP: begin
                    if (adc.SensorReady_i)  state_d = ST_CONVERT;
                    else if (rdy_zero)      state_d = ST_IDLE;
                end
                ST_CONVERT:  if (adc.AdcDone_i) state_d = ST_EVAL;
                ST_EVAL:     state_d = (idx_q == LAST_IDX) ? ST_NOTIFY : ST_CONVERT;
                ST_NOTIFY:   state_d = ST_IDLE;
                default:     state_d = ST_DISABLED;
            endcase
        end
    end

    // Datapath updates: scan bookkeeping, threshold compare, error flag (set beats clear)
    always_comb begin
        idx_d          = idx_q;
        sample_d       = sample_q;
        round_mask_d   = round_mask_q;
        changed_mask_d = changed_mask_q;
        stored_d       = stored_q;
        if (Enable_i) begin
            case (state_q)
                ST_IDLE: begin
                    if (period_zero) begin
                        idx_d        = '0;
                        round_mask_d = '0;
                    end
                end
                ST_CONVERT: begin
                    if (adc.AdcDone_i) sample_d = adc.AdcValue_i;
                end
                ST_EVAL: begin
                    if (over_thr) begin
                        stored_d[idx_q]     = sample_q;
                        round_mask_d[idx_q] = 1'b1;
                    end
                    if (idx_q != LAST_IDX) idx_d = idx_q + IW'(1);
                end
                ST_NOTIFY: changed_mask_d = round_mask_q;
                default: ;
            endcase
        end
        if (Enable_i && ready_timeout) error_d = 1'b1;
        else if (ErrorClr_i)           error_d = 1'b0;
        else                           error_d = error_q;
    end

    // Moore-style outputs per state, all forced low while disabled
    always_comb begin
        adc.SensorPower_o = 1'b0;
        adc.SensorStart_o = 1'b0;
        adc.AdcStart_o    = 1'b0;
        adc.AdcChannel_o  = '0;
        CpuIntr_o         = 1'b0;
        if (Enable_i) begin
            case (state_q)
                ST_POWERUP: begin
                    adc.SensorPower_o = 1'b1;
                    adc.SensorStart_o = 1'b1;
                    CpuIntr_o         = ready_timeout;
                end
                ST_CONVERT: begin
                    adc.SensorPower_o = 1'b1;
                    adc.AdcStart_o    = 1'b1;
                    adc.AdcChannel_o  = idx_q;
                end
                ST_EVAL:   adc.SensorPower_o = 1'b1;
                ST_NOTIFY: CpuIntr_o = |round_mask_q;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ext_adc_scan.sv
// Directed bench for ext_adc_scan: scans, change masks, ready timeout, enable drop, reset.
// Latency: n/a.
// Backpressure: ADC responder raises done two sampling edges after start.
`timescale 1ns/1ps
module tb_ext_adc_scan;
    localparam int W  = 16;
    localparam int N  = 4;
    localparam int TW = 16;

    logic           clk = 1'b0;
    logic           rst, en, err_clr;
    logic [TW-1:0]  preset, rto;
    logic [N*W-1:0] thr, sval;
    logic [N-1:0]   cmask;
    logic           irq, err;
    logic           sensor_ready;
    logic           adc_done  = 1'b0;
    logic [W-1:0]   adc_value = '0;
    logic [W-1:0]   adc_tbl [N];
    logic [15:0]    ch_log = '0;
    int             adc_cnt = 0;
    int             irq_cnt = 0;
    int             n_checks = 0;
    int             n_pass = 0;
    logic           mon_en = 1'b0;
    logic           xseen  = 1'b0;

    always #5 clk = ~clk;

    ext_adc_scan_if #(.WIDTH(W), .NUM_CH(N)) adc_if ();
    assign adc_if.SensorReady_i = sensor_ready;
    assign adc_if.AdcDone_i     = adc_done;
    assign adc_if.AdcValue_i    = adc_value;

    ext_adc_scan #(.WIDTH(W), .NUM_CH(N), .TIMER_WIDTH(TW)) dut (
        .Clk_i                 (clk),
        .Reset_i               (rst),
        .Enable_i              (en),
        .PeriodCounterPreset_i (preset),
        .ReadyTimeout_i        (rto),
        .Threshold_i           (thr),
        .adc                   (adc_if),
        .SensorValue_o         (sval),
        .ChangedMask_o         (cmask),
        .CpuIntr_o             (irq),
        .Error_o               (err),
        .ErrorClr_i            (err_clr)
    );

    // ADC model: done two sampling edges after start rises, value from table, logs channel order
    always @(negedge clk) begin
        if (adc_if.AdcStart_o === 1'b1) begin
            adc_cnt++;
            if (adc_cnt == 2) begin
                adc_done  = 1'b1;
                adc_value = adc_tbl[adc_if.AdcChannel_o];
                ch_log    = {ch_log[11:0], 2'b00, adc_if.AdcChannel_o};
            end
        end else begin
            adc_cnt  = 0;
            adc_done = 1'b0;
        end
    end

    // Interrupt pulse counter and unknown-value watch
    always @(negedge clk) begin
        if (irq === 1'b1) irq_cnt++;
        if (mon_en && $isunknown({adc_if.SensorPower_o, adc_if.SensorStart_o, adc_if.AdcStart_o,
                                  adc_if.AdcChannel_o, irq, err, cmask, sval}))
            xseen = 1'b1;
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic wait_power(input logic lvl, input string tag);
        int i;
        i = 0;
        while (adc_if.SensorPower_o !== lvl && i < 200) begin
            @(negedge clk);
            i++;
        end
        check(tag, adc_if.SensorPower_o, lvl);
    endtask

    initial begin
        int n;
        rst = 1'b1; en = 1'b0; err_clr = 1'b0;
        preset = 16'd3; rto = 16'd10; thr = {4{16'd10}};
        sensor_ready = 1'b1;
        adc_tbl = '{16'd10, 16'd11, 16'd0, 16'd500};
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_handshake", {adc_if.SensorPower_o, adc_if.SensorStart_o, adc_if.AdcStart_o,
                                adc_if.AdcChannel_o}, 5'b0);
        check("rst_irq_err", {irq, err}, 2'b00);
        check("rst_mask", cmask, 4'b0);
        check("rst_values", sval, 64'h0);

        // Scan 1: idle length, channel order, change mask 1010
        rst = 1'b0; mon_en = 1'b1; en = 1'b1; ch_log = '0;
        n = 0;
        @(negedge clk);
        while (adc_if.SensorPower_o !== 1'b1 && n < 50) begin
            n++;
            @(negedge clk);
        end
        check("idle_cycles", n, 4);
        check("powerup_outputs", {adc_if.SensorPower_o, adc_if.SensorStart_o}, 2'b11);
        wait_power(1'b0, "scan1_end");
        check("scan1_notify_irq", irq, 1'b1);
        @(negedge clk);
        check("scan1_mask", cmask, 4'b1010);
        check("scan1_values", sval, {16'd500, 16'd0, 16'd11, 16'd0});
        check("scan1_irq_cnt", irq_cnt, 1);
        check("scan1_ch_order", ch_log, 16'h0123);

        // Scan 2: same samples, nothing moves
        wait_power(1'b1, "scan2_start");
        wait_power(1'b0, "scan2_end");
        check("scan2_notify_irq", irq, 1'b0);
        @(negedge clk);
        check("scan2_mask", cmask, 4'b0000);
        check("scan2_values", sval, {16'd500, 16'd0, 16'd11, 16'd0});
        check("scan2_irq_cnt", irq_cnt, 1);

        // Ready timeout: 6 powerup cycles, one IRQ, error set, power off
        rto = 16'd5; sensor_ready = 1'b0;
        wait_power(1'b1, "to_start");
        n = 1;
        while (n < 50) begin
            @(negedge clk);
            if (adc_if.SensorPower_o === 1'b1) n++;
            else break;
        end
        check("to_powerup_cycles", n, 6);
        check("to_error", err, 1'b1);
        check("to_irq_cnt", irq_cnt, 2);
        check("to_power_off", {adc_if.SensorPower_o, adc_if.SensorStart_o}, 2'b00);

        // Clear works; a timeout in the same cycle as a clear still sets the flag
        err_clr = 1'b1;
        @(negedge clk);
        check("err_cleared", err, 1'b0);
        wait_power(1'b1, "to2_start");
        wait_power(1'b0, "to2_end");
        check("err_set_wins", err, 1'b1);
        err_clr = 1'b0; sensor_ready = 1'b1;
        adc_tbl = '{16'd100, 16'd200, 16'd300, 16'd400};

        // Enable drop during CONVERT of channel 2
        n = 0;
        while (!(adc_if.AdcStart_o === 1'b1 && adc_if.AdcChannel_o === 2'd2) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("reach_ch2", {adc_if.AdcStart_o, adc_if.AdcChannel_o}, 3'b110);
        en = 1'b0;
        @(negedge clk);
        check("dis_outputs", {adc_if.SensorPower_o, adc_if.SensorStart_o, adc_if.AdcStart_o,
                              adc_if.AdcChannel_o, irq}, 6'b0);
        check("dis_values", sval, {16'd500, 16'd0, 16'd200, 16'd100});
        check("dis_mask_err", {cmask, err}, 5'b0000_1);

        // Re-enable: ch2 and ch3 move past threshold
        en = 1'b1;
        wait_power(1'b1, "scan3_start");
        wait_power(1'b0, "scan3_end");
        check("scan3_notify_irq", irq, 1'b1);
        @(negedge clk);
        check("scan3_mask", cmask, 4'b1100);
        check("scan3_values", sval, {16'd400, 16'd300, 16'd200, 16'd100});
        check("scan3_irq_cnt", irq_cnt, 4);

        // Reset mid-scan with error set and clear asserted
        n = 0;
        while (adc_if.AdcStart_o !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("pre_rst_convert", {adc_if.AdcStart_o, err}, 2'b11);
        rst = 1'b1; err_clr = 1'b1;
        @(negedge clk);
        check("mid_rst_outputs", {adc_if.SensorPower_o, adc_if.SensorStart_o, adc_if.AdcStart_o,
                                  adc_if.AdcChannel_o, irq, err}, 7'b0);
        check("mid_rst_mask", cmask, 4'b0);
        check("mid_rst_values", sval, 64'h0);
        check("no_x_outputs", xseen, 1'b0);

        rst = 1'b0; err_clr = 1'b0; en = 1'b0;
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
